neuron_accumulator: RTL and testbench
=====================================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits (two's complement), legal range 17..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port clear, input, 1, synchronous discard of the partial sum.
REQ-005 SHALL have port in_valid, input, 1, a product beat is present.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a beat this cycle.
REQ-007 SHALL have port in_prod, input, 16, sign-magnitude product: bit15 is the sign, bits14:0 are the magnitude (8x8 sign-magnitude multiplier format).
REQ-008 SHALL have port in_last, input, 1, marks the final product of a neuron.
REQ-009 SHALL have port out_valid, output, 1, a result is held.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port out_sum, output, 16, sign-magnitude neuron result.
REQ-012 SHALL have port out_sat, output, 1, the result was clamped.

Function
REQ-013 SHALL implement states IDLE (sum=0, no beat yet), ACCUM (at least one beat taken), HOLD (result presented).
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-015 SHALL accept a beat iff in_valid && in_ready; non-accepted cycles leave the sum unchanged.
REQ-016 SHALL convert an accepted beat to two's complement as +mag when bit15=0 and -mag when bit15=1; 0x8000 (negative zero) SHALL add 0.
REQ-017 SHALL add the converted value to the ACC_W-bit sum with wrap-around at ACC_W bits (no internal saturation).
REQ-018 SHALL move IDLE->ACCUM on an accepted beat with in_last=0, and IDLE/ACCUM->HOLD on an accepted beat with in_last=1.
REQ-019 SHALL register the result so that out_valid rises exactly one cycle after the in_last beat is accepted, and the result includes that beat.
REQ-020 SHALL form out_sum from the final sum: sign = sum<0; magnitude = |sum| clamped to 32767. out_sat=1 iff clamping occurred. A zero sum SHALL give 0x0000.
REQ-021 SHALL hold out_valid, out_sum and out_sat stable in HOLD until out_valid && out_ready.
REQ-022 SHALL, on the output handshake, clear the sum and return to IDLE next cycle with out_valid=0; in_ready SHALL first be 1 in that next cycle.
REQ-023 SHALL treat clear=1 as highest priority in IDLE/ACCUM: zero the sum, go to IDLE, and ignore a beat accepted in the same cycle.
REQ-024 SHALL ignore clear while in HOLD; the held result is not disturbed.
REQ-025 SHALL keep out_sum/out_sat at their last value when out_valid=0; consumers SHALL NOT sample them then.

Reset
REQ-026 SHALL, while rst_n=0, force: state=IDLE, sum=0, out_valid=0, out_sum=0x0000, out_sat=0, in_ready=0.
REQ-027 SHALL take effect asynchronously on assertion, including mid-accumulation and in HOLD; the partial sum or held result is lost.
REQ-028 SHALL drive in_ready=1 from the first clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL honour the macro NEURON_ACC_RELU_EN.
REQ-030 With NEURON_ACC_RELU_EN defined, a negative final sum SHALL yield out_sum=0x0000 and out_sat=0; a positive sum is unchanged.
REQ-031 Without NEURON_ACC_RELU_EN, out_sum SHALL carry the signed result per REQ-020.

Verification
REQ-032 SHALL cover this case: beats 0x0005, 0x8003, 0x0010 (last) with out_ready=1 -> out_sum=0x0012 one cycle after the last beat, out_sat=0.
REQ-033 SHALL cover this case: 3 beats of 0x7FFF, last on the third -> out_sum=0x7FFF, out_sat=1; with 3 beats of 0xFFFF -> 0xFFFF, out_sat=1 (0x0000, out_sat=0 under RELU_EN).
REQ-034 SHALL cover this case: result held, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout and out_sum stable; no beat absorbed.
REQ-035 SHALL cover this case: 0x8000 (last) -> out_sum=0x0000; 0x0004 then 0x8009 (last) -> 0x8005 (0x0000 under RELU_EN).
REQ-036 SHALL cover this case: clear asserted together with an accepted beat of 0x0007 after 0x0003 -> IDLE, then 0x0001 (last) gives 0x0001.
REQ-037 SHALL cover this case: rst_n pulsed low asynchronously mid-accumulation and again in HOLD -> out_valid=0 immediately; the next neuron's sum starts from 0.

Source files
------------

// File: rtl/neuron_accumulator.sv
// Sign-magnitude product accumulator with a clamped sign-magnitude result.
// Optional NEURON_ACC_RELU_EN: negative results are reported as zero.
module neuron_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_prod,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_sat
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_run;
  logic [ACC_W-1:0] r_sum;

  logic             w_take;
  logic [ACC_W-1:0] w_beat;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_total;
  logic             w_neg;
  logic [ACC_W-1:0] w_abs;
  logic             w_big;
  logic [14:0]      w_mag;
  logic [15:0]      w_res;
  logic             w_sat;

  // r_run keeps in_ready low until the first edge after reset release
  assign in_ready  = r_run && (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign w_take    = in_valid && in_ready;

  assign w_beat   = {{(ACC_W-15){1'b0}}, in_prod[14:0]};
  assign w_addend = in_prod[15] ? -w_beat : w_beat;
  assign w_total  = r_sum + w_addend;

  assign w_neg = w_total[ACC_W-1];
  assign w_abs = w_neg ? -w_total : w_total;
  assign w_big = |w_abs[ACC_W-1:15];
  assign w_mag = w_big ? 15'h7FFF : w_abs[14:0];

`ifdef NEURON_ACC_RELU_EN
  assign w_res = w_neg ? 16'h0000 : {1'b0, w_mag};
  assign w_sat = !w_neg && w_big;
`else
  assign w_res = {w_neg, w_mag};
  assign w_sat = w_big;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, ACCUM: begin
        if (clear)
          w_next = IDLE;
        else if (w_take)
          w_next = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (out_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_sum   <= '0;
      out_sum <= 16'h0000;
      out_sat <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_state == HOLD) begin
        if (out_ready)
          r_sum <= '0;
      end else if (clear) begin
        r_sum <= '0;
      end else if (w_take) begin
        r_sum <= w_total;
        if (in_last) begin
          out_sum <= w_res;
          out_sat <= w_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomised and directed bench for neuron_accumulator.
// Expected results come from an integer model of the neuron sum.
module tb_neuron_accumulator;

  localparam int ACC_W = 24;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

  logic [15:0] beats[$];
  longint      m_sum;
  logic [16:0] m_exp;

  neuron_accumulator #(.ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint conv(input logic [15:0] p);
    longint mag;
    mag = longint'(p[14:0]);
    return p[15] ? -mag : mag;
  endfunction

  // {sat, sign-magnitude result} of an arbitrary-precision sum
  function automatic logic [16:0] model(input longint s);
    longint m;
    longint w;
    longint a;
    bit     neg;
    bit     sat;
    logic [15:0] r;
    m = longint'(1) << ACC_W;
    w = s % m;
    if (w < 0) w += m;
    if (w >= m / 2) w -= m;
    neg = (w < 0);
    a   = neg ? -w : w;
    sat = (a > 32767);
    if (sat) a = 32767;
    r = {neg, a[14:0]};
`ifdef NEURON_ACC_RELU_EN
    if (neg) begin
      r   = 16'h0000;
      sat = 1'b0;
    end
`endif
    return {sat, r};
  endfunction

  task automatic feed(input bit ordy, input int gap_max);
    int g;
    m_sum = 0;
    out_ready = ordy;
    foreach (beats[i]) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_prod  = 16'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_prod  = beats[i];
      in_last  = (i == beats.size() - 1);
      chk("in_ready", 32'(in_ready), 32'd1);
      m_sum += conv(beats[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_exp = model(m_sum);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_sum", 32'(out_sum), 32'(m_exp[15:0]));
    chk("out_sat", 32'(out_sat), 32'(m_exp[16]));
  endtask

  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(m_exp[15:0]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_sum"}, 32'(out_sum), 32'd0);
    chk({tag, "_sat"}, 32'(out_sat), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] held;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    #5 rst_n = 1'b1;
    #1 chk("rel_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("edge_rdy", 32'(in_ready), 32'd1);

    beats = '{16'h0005, 16'h8003, 16'h0010};
    feed(1'b1, 0);
    chk("basic_sum", 32'(out_sum), 32'h0012);
    drain(0);

    beats = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    feed(1'b0, 0);
    chk("posat_sum", 32'(out_sum), 32'h7FFF);
    chk("posat_sat", 32'(out_sat), 32'd1);
    drain(1);

    beats = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    feed(1'b0, 1);
    drain(2);

    beats = '{16'h8000};
    feed(1'b0, 0);
    chk("negzero", 32'(out_sum), 32'h0000);
    drain(0);

    beats = '{16'h0004, 16'h8009};
    feed(1'b0, 0);
    drain(0);

    // clear wins over a beat in the same cycle
    in_valid = 1'b1; in_prod = 16'h0003; in_last = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1; in_prod = 16'h0007;
    chk("clr_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    clear = 1'b0;
    beats = '{16'h0001};
    feed(1'b0, 0);
    chk("clr_sum", 32'(out_sum), 32'h0001);
    drain(0);

    // held result with pressure on the input side and clear
    beats = '{16'h0020, 16'h0021};
    feed(1'b0, 0);
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_prod = 16'h1234; in_last = 1'b1;
      clear = (i == 2);
      @(posedge clk); #1;
      chk("hold_rdy", 32'(in_ready), 32'd0);
      chk("hold_stable", 32'(out_sum), 32'(held));
    end
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    drain(0);
    beats = '{16'h0001};
    feed(1'b0, 0);
    chk("noabsorb", 32'(out_sum), 32'h0001);
    drain(0);

    // asynchronous reset mid-accumulation, then in HOLD
    in_valid = 1'b1; in_prod = 16'h0100; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_reset("rst_acc");
    beats = '{16'h0002};
    feed(1'b0, 0);
    chk("post_rst_sum", 32'(out_sum), 32'h0002);
    drain(0);
    beats = '{16'h0050};
    feed(1'b0, 0);
    pulse_reset("rst_hold");
    beats = '{16'h0003};
    feed(1'b0, 0);
    chk("post_hold_sum", 32'(out_sum), 32'h0003);
    drain(0);

    // long run that wraps the accumulator
    beats = {};
    repeat (300) beats.push_back(16'h7FFF);
    feed(1'b0, 0);
    drain(0);

    for (int k = 0; k < 40; k++) begin
      beats = {};
      n = int'($urandom_range(6, 1));
      repeat (n) begin
        if ($urandom_range(3, 0) == 0)
          beats.push_back({1'($urandom), 15'($urandom_range(32767, 28672))});
        else
          beats.push_back(16'($urandom));
      end
      feed(1'($urandom), 2);
      drain(int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
